// File: rtl/round_controller.sv
// round_controller: game-round sequencer driving a countdown timer's go/restart
// inputs, latching the final score and flagging low time.
`default_nettype none

module round_controller #(
  parameter int          SETTLE_CYCLES  = 2,
  parameter logic [7:0]  WARN_THRESHOLD = 8'd30,
  parameter int          SCORE_WIDTH    = 10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   pause,
  input  logic [7:0]             time_left,
  input  logic [SCORE_WIDTH-1:0] score,
  output logic                   timer_go,
  output logic                   restart,
  output logic [2:0]             state,
  output logic                   round_over,
  output logic                   low_time,
  output logic [SCORE_WIDTH-1:0] final_score
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOADING   = 3'd1;
  localparam logic [2:0] S_RUNNING   = 3'd2;
  localparam logic [2:0] S_PAUSED    = 3'd3;
  localparam logic [2:0] S_GAME_OVER = 3'd4;

  localparam int          c_CW     = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_CW-1:0] c_SETTLE = c_CW'(SETTLE_CYCLES);

  logic [2:0]             r_state;
  logic [c_CW-1:0]        r_cnt;
  logic                   r_timer_go;
  logic                   r_restart;
  logic                   r_round_over;
  logic                   r_low_time;
  logic [SCORE_WIDTH-1:0] r_final_score;

  logic [2:0] w_next;
  logic       w_load;
  logic       w_over;
  logic       w_bad;
  logic       w_low;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_over = 1'b0;
    w_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_LOADING;
          w_load = 1'b1;
        end
      end
      S_LOADING: begin
        if (r_cnt == c_SETTLE) w_next = S_RUNNING;
      end
      S_RUNNING: begin
        // Timer expiry outranks a coincident pause.
        if (time_left == 8'd0) begin
          w_next = S_GAME_OVER;
          w_over = 1'b1;
        end else if (pause) begin
          w_next = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (start) begin
          w_next = S_LOADING;
          w_load = 1'b1;
        end else if (pause) begin
          w_next = S_RUNNING;
        end
      end
      S_GAME_OVER: begin
        if (start) begin
          w_next = S_LOADING;
          w_load = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
        w_bad  = 1'b1;
      end
    endcase
  end

  // Warning follows the state being entered so it is clear in LOADING/GAME_OVER.
  assign w_low = ((w_next == S_RUNNING) || (w_next == S_PAUSED)) &&
                 (time_left != 8'd0) && (time_left <= WARN_THRESHOLD);

  always_ff @(posedge clock) begin
    if (!reset_n || w_bad) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_timer_go    <= 1'b0;
      r_restart     <= 1'b0;
      r_round_over  <= 1'b0;
      r_low_time    <= 1'b0;
      r_final_score <= '0;
    end else begin
      r_state      <= w_next;
      r_timer_go   <= (w_next == S_RUNNING);
      r_restart    <= w_load;
      r_round_over <= w_over;
      r_low_time   <= w_low;
      if (w_over) r_final_score <= score;
      if (w_load) r_cnt <= '0;
      else if (r_state == S_LOADING) r_cnt <= r_cnt + c_CW'(1);
    end
  end

  assign state       = r_state;
  assign timer_go    = r_timer_go;
  assign restart     = r_restart;
  assign round_over  = r_round_over;
  assign low_time    = r_low_time;
  assign final_score = r_final_score;

endmodule

`default_nettype wire
